// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM definitions: geometry of the word address, default bus
// widths and the one-hot state encoding of the two-master arbiter.
// No ports; imported by sdram_arbiter and rr_pick2.
package sdram_arbiter_pkg;

    // Word address = bank + row + column.
    localparam int SDRAM_BANK_WIDTH    = 2;
    localparam int SDRAM_ROW_WIDTH     = 11;
    localparam int SDRAM_COL_WIDTH     = 8;
    localparam int SDRAM_ADDRESS_WIDTH = SDRAM_BANK_WIDTH + SDRAM_ROW_WIDTH + SDRAM_COL_WIDTH;
    localparam int SDRAM_DATA_WIDTH    = 32;

    typedef enum logic [3:0] {
        ARB_IDLE     = 4'b0001,
        ARB_GRANT    = 4'b0010,
        ARB_COMPLETE = 4'b0100,
        ARB_RELEASE  = 4'b1000
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_rr_pick2.sv
// rr_pick2: combinational two-requester round-robin selector.
//   eligible[1:0] : per-requester eligibility
//   last_grant    : requester served most recently
//   valid         : at least one requester is eligible
//   grant         : selected requester index (meaningful when valid=1)
module rr_pick2 (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    // On contention the requester that was not served last wins; otherwise
    // the single eligible requester is taken.
    assign valid = |eligible;
    assign grant = (eligible == 2'b11) ? ~last_grant : eligible[1];

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller request port between two
// masters with round-robin arbitration and a four-phase req/ack handshake
// on every port.
//   clk, nreset                      : clock, synchronous active-low reset
//   mN_address/data_in/nwr/req       : master N request fields (N = 0,1)
//   mN_data_out, mN_ack              : master N registered response
//   mem_address/data_out/nwr/req     : registered request to the controller
//   mem_ack, mem_data_in             : controller completion and read data
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = SDRAM_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = SDRAM_ADDRESS_WIDTH
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [ADDRESS_WIDTH-1:0]  m0_address,
    input  logic [DATA_WIDTH-1:0]     m0_data_in,
    input  logic [DATA_WIDTH/8-1:0]   m0_nwr,
    input  logic                      m0_req,
    output logic [DATA_WIDTH-1:0]     m0_data_out,
    output logic                      m0_ack,
    input  logic [ADDRESS_WIDTH-1:0]  m1_address,
    input  logic [DATA_WIDTH-1:0]     m1_data_in,
    input  logic [DATA_WIDTH/8-1:0]   m1_nwr,
    input  logic                      m1_req,
    output logic [DATA_WIDTH-1:0]     m1_data_out,
    output logic                      m1_ack,
    output logic [ADDRESS_WIDTH-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic [DATA_WIDTH/8-1:0]   mem_nwr,
    output logic                      mem_req,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_data_in
);

    arb_state_t state_reg;
    logic       grant_reg;
    logic       last_grant_reg;

    logic [1:0] eligible;
    logic       pick_valid;
    logic       pick_grant;
    logic       granted_req;

    // A master whose ack is still high has not finished its handshake and
    // must not be granted again.
    assign eligible    = {m1_req & ~m1_ack, m0_req & ~m0_ack};
    assign granted_req = grant_reg ? m1_req : m0_req;

    rr_pick2 u_rr_pick2 (
        .eligible   (eligible),
        .last_grant (last_grant_reg),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    // Address and data registers carry no reset value; they only matter
    // while mem_req or an ack is high.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg      <= ARB_IDLE;
            mem_req        <= 1'b0;
            m0_ack         <= 1'b0;
            m1_ack         <= 1'b0;
            last_grant_reg <= 1'b1;
            mem_nwr        <= '1;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_reg    <= pick_grant;
                        mem_address  <= pick_grant ? m1_address : m0_address;
                        mem_data_out <= pick_grant ? m1_data_in : m0_data_in;
                        mem_nwr      <= pick_grant ? m1_nwr     : m0_nwr;
                        mem_req      <= 1'b1;
                        state_reg    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (mem_ack) begin
                        mem_req        <= 1'b0;
                        last_grant_reg <= grant_reg;
                        // Read data is returned for writes too; the master
                        // simply ignores it.
                        if (grant_reg) begin
                            m1_data_out <= mem_data_in;
                            m1_ack      <= 1'b1;
                        end else begin
                            m0_data_out <= mem_data_in;
                            m0_ack      <= 1'b1;
                        end
                        state_reg <= ARB_COMPLETE;
                    end
                end
                ARB_COMPLETE: begin
                    // Controller must release its ack before the next request.
                    if (!mem_ack) begin
                        state_reg <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    if (!granted_req) begin
                        if (grant_reg) begin
                            m1_ack <= 1'b0;
                        end else begin
                            m0_ack <= 1'b0;
                        end
                        state_reg <= ARB_IDLE;
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed transactions, a controller model,
// and a scoreboard monitor that checks mem_* fields while mem_req is high
// and the returned data on every ack rise.
module tb_sdram_arbiter;

    typedef struct {
        int          m;
        logic [20:0] addr;
        logic [31:0] wdata;
        logic [3:0]  nwr;
        logic [31:0] rdata;
        int          delay;
    } txn_t;

    logic        clk;
    logic        nreset;
    logic [20:0] m0_address, m1_address, mem_address;
    logic [31:0] m0_data_in, m1_data_in, m0_data_out, m1_data_out;
    logic [3:0]  m0_nwr, m1_nwr, mem_nwr;
    logic        m0_req, m1_req, m0_ack, m1_ack;
    logic [31:0] mem_data_out, mem_data_in;
    logic        mem_req, mem_ack;

    int   errors = 0;
    int   checks = 0;
    txn_t exp_q[$];
    txn_t ctrl_q[$];
    int   ctrl_cnt = 0;
    logic prev_ack0 = 1'b0;
    logic prev_ack1 = 1'b0;
    logic [31:0] last_data [2];
    logic        data_valid [2] = '{1'b0, 1'b0};

    sdram_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(21)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .m0_address   (m0_address),
        .m0_data_in   (m0_data_in),
        .m0_nwr       (m0_nwr),
        .m0_req       (m0_req),
        .m0_data_out  (m0_data_out),
        .m0_ack       (m0_ack),
        .m1_address   (m1_address),
        .m1_data_in   (m1_data_in),
        .m1_nwr       (m1_nwr),
        .m1_req       (m1_req),
        .m1_data_out  (m1_data_out),
        .m1_ack       (m1_ack),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_nwr      (mem_nwr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_data_in  (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_ack(input int m);
        return (m == 1) ? m1_ack : m0_ack;
    endfunction

    function automatic logic [31:0] get_data(input int m);
        return (m == 1) ? m1_data_out : m0_data_out;
    endfunction

    task automatic push_txn(input int m, input logic [20:0] addr, input logic [31:0] wd,
                            input logic [3:0] nwr, input logic [31:0] rd, input int dly);
        txn_t t;
        t.m = m; t.addr = addr; t.wdata = wd; t.nwr = nwr; t.rdata = rd; t.delay = dly;
        exp_q.push_back(t);
        ctrl_q.push_back(t);
    endtask

    // Controller model: acks after 'delay' cycles of mem_req, holds ack
    // until mem_req drops.
    always @(posedge clk) begin
        if (!nreset) begin
            mem_ack  <= 1'b0;
            ctrl_cnt <= 0;
        end else if (mem_ack) begin
            if (!mem_req) mem_ack <= 1'b0;
        end else if (mem_req && ctrl_q.size() > 0) begin
            if (ctrl_cnt >= ctrl_q[0].delay) begin
                mem_ack     <= 1'b1;
                mem_data_in <= ctrl_q[0].rdata;
                void'(ctrl_q.pop_front());
                ctrl_cnt    <= 0;
            end else begin
                ctrl_cnt <= ctrl_cnt + 1;
            end
        end
    end

    task automatic ack_rise(input int m);
        txn_t e;
        int   other;
        other = 1 - m;
        if (exp_q.size() == 0) begin
            check("unexpected_ack", 64'(m), 64'hFF);
        end else begin
            e = exp_q.pop_front();
            $display("txn done: m%0d addr=%0h nwr=%0h data_out=%0h", m, e.addr, e.nwr, get_data(m));
            check("grant_order", 64'(m), 64'(e.m));
            check("data_out", 64'(get_data(m)), 64'(e.rdata));
            if (data_valid[other]) check("other_data_hold", 64'(get_data(other)), 64'(last_data[other]));
            last_data[m]  = e.rdata;
            data_valid[m] = 1'b1;
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (nreset) begin
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mem_req", 64'(mem_req), 64'h0);
                end else begin
                    check("mem_address", 64'(mem_address), 64'(exp_q[0].addr));
                    check("mem_data_out", 64'(mem_data_out), 64'(exp_q[0].wdata));
                    check("mem_nwr", 64'(mem_nwr), 64'(exp_q[0].nwr));
                    check("acks_low_in_grant", 64'({m1_ack, m0_ack}), 64'h0);
                end
            end
            if (m0_ack && !prev_ack0) ack_rise(0);
            if (m1_ack && !prev_ack1) ack_rise(1);
        end
        prev_ack0 = m0_ack;
        prev_ack1 = m1_ack;
    end

    // Caller is aligned just after a rising edge.
    task automatic master_txn(input int m, input logic [20:0] addr, input logic [31:0] wd,
                              input logic [3:0] nwr, input int hold);
        int n;
        if (m == 0) begin
            m0_address = addr; m0_data_in = wd; m0_nwr = nwr; m0_req = 1'b1;
        end else begin
            m1_address = addr; m1_data_in = wd; m1_nwr = nwr; m1_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!get_ack(m) && n < 300);
        check("ack_seen", 64'(get_ack(m)), 64'h1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ack_held", 64'(get_ack(m)), 64'h1);
            check("no_mem_req_while_held", 64'(mem_req), 64'h0);
        end
        @(posedge clk);
        #1;
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (get_ack(m) && n < 50);
        check("ack_clear", 64'(get_ack(m)), 64'h0);
    endtask

    initial begin
        int n;
        nreset = 1'b0;
        m0_address = '0; m0_data_in = '0; m0_nwr = 4'hF; m0_req = 1'b0;
        m1_address = '0; m1_data_in = '0; m1_nwr = 4'hF; m1_req = 1'b0;
        mem_data_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mem_req", 64'(mem_req), 64'h0);
        check("reset_acks", 64'({m1_ack, m0_ack}), 64'h0);
        check("reset_mem_nwr", 64'(mem_nwr), 64'hF);
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // Contention right after reset: m0 first, then alternate per pair
        for (int p = 0; p < 4; p++) begin
            push_txn(0, 21'h00100 + 21'(p), 32'h0000_0000 + 32'(p), 4'hF, 32'hA000_0000 + 32'(p), 2);
            push_txn(1, 21'h00200 + 21'(p), 32'h0000_1000 + 32'(p), 4'hF, 32'hB000_0000 + 32'(p), 1);
            @(posedge clk);
            #1;
            fork
                master_txn(0, 21'h00100 + 21'(p), 32'h0000_0000 + 32'(p), 4'hF, 0);
                master_txn(1, 21'h00200 + 21'(p), 32'h0000_1000 + 32'(p), 4'hF, 0);
            join
        end

        // Single read with one-cycle request latency
        push_txn(0, 21'h00123, 32'h0, 4'hF, 32'hDEAD_BEEF, 0);
        @(posedge clk);
        #1;
        fork
            master_txn(0, 21'h00123, 32'h0, 4'hF, 0);
            begin
                @(negedge clk);
                check("mem_req_before_sample", 64'(mem_req), 64'h0);
                @(negedge clk);
                check("mem_req_one_cycle", 64'(mem_req), 64'h1);
            end
        join

        // Byte write by m1
        push_txn(1, 21'h1ABCD, 32'h1122_3344, 4'b1110, 32'hCAFE_0001, 3);
        @(posedge clk);
        #1;
        master_txn(1, 21'h1ABCD, 32'h1122_3344, 4'b1110, 0);
        check("m0_data_after_m1_write", 64'(m0_data_out), 64'hDEAD_BEEF);

        // Controller stall of 20 cycles
        push_txn(0, 21'h0F0F0, 32'h55AA_55AA, 4'b0000, 32'h1234_5678, 20);
        @(posedge clk);
        #1;
        master_txn(0, 21'h0F0F0, 32'h55AA_55AA, 4'b0000, 0);

        // Slow release by m0 with m1 pending
        push_txn(0, 21'h00042, 32'h0, 4'hF, 32'h0BAD_F00D, 4);
        push_txn(1, 21'h00077, 32'h0, 4'hF, 32'h600D_CAFE, 0);
        @(posedge clk);
        #1;
        fork
            begin
                master_txn(0, 21'h00042, 32'h0, 4'hF, 5);
                @(negedge clk);
                check("m1_grant_after_release", 64'(mem_req), 64'h1);
                check("m1_grant_addr", 64'(mem_address), 64'h00077);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                master_txn(1, 21'h00077, 32'h0, 4'hF, 0);
            end
        join

        // Reset while in GRANT
        push_txn(0, 21'h00321, 32'h0, 4'hF, 32'hFFFF_FFFF, 1000);
        @(posedge clk);
        #1;
        m0_address = 21'h00321; m0_data_in = 32'h0; m0_nwr = 4'hF; m0_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 50);
        check("grant_before_reset", 64'(mem_req), 64'h1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        nreset = 1'b0;
        m0_req = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (ctrl_q.size() > 0) void'(ctrl_q.pop_front());
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        $display("txn abandoned by reset: mem_req=%0b acks=%0b%0b", mem_req, m1_ack, m0_ack);
        check("reset_grant_mem_req", 64'(mem_req), 64'h0);
        check("reset_grant_acks", 64'({m1_ack, m0_ack}), 64'h0);

        // Normal transaction after the reset
        push_txn(1, 21'h00555, 32'h0, 4'hF, 32'h1357_9BDF, 2);
        @(posedge clk);
        #1;
        master_txn(1, 21'h00555, 32'h0, 4'hF, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        check("controller_queue_empty", 64'(ctrl_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
